// File: rtl/chan_sw_latch.sv
// rtl/chan_sw_latch.sv - N-channel registered switch with break-before-make blanking, select handshake and hold
// A changeover blanks y for BLANK cycles before the new channel is connected.

module chan_sw_latch #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int BLANK = 2,
    parameter int SELW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    din,
    input  logic              sel_valid,
    input  logic [SELW-1:0]   sel_req,
    output logic              sel_ready,
    input  logic              hold,
    output logic [W-1:0]      y,
    output logic              y_valid,
    output logic [SELW-1:0]   cur_sel,
    output logic              busy,
    output logic              err
);

    localparam int CW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
    localparam logic [CW-1:0]   BLANK_L = CW'(BLANK);
    localparam logic [SELW:0]   N_L     = (SELW + 1)'(N);

    typedef enum logic {
        ST_RUN,
        ST_BLANK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SELW-1:0] tgt_q, tgt_d;
    logic [SELW-1:0] cur_d;
    logic [W-1:0]    y_d;
    logic            yv_d;
    logic            busy_d;
    logic            err_d;
    logic            rdy_d;

    logic            accept;
    logic            req_oor;
    logic [W-1:0]    cur_data;
    logic [W-1:0]    req_data;
    logic [W-1:0]    tgt_data;

    // Out-of-range indices select nothing and yield zero.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus, input logic [SELW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SELW'(i)) begin
                r = bus[i*W +: W];
            end
        end
        return r;
    endfunction

    always_comb begin
        cur_data = pick(din, cur_sel);
        req_data = pick(din, sel_req);
        tgt_data = pick(din, tgt_q);
        accept   = sel_valid & sel_ready;
        req_oor  = ({1'b0, sel_req} >= N_L);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        cur_d   = cur_sel;
        y_d     = y;
        yv_d    = y_valid;
        busy_d  = busy;
        err_d   = 1'b0;
        rdy_d   = sel_ready;

        case (state_q)
            ST_RUN: begin
                if (!hold) begin
                    y_d  = cur_data;
                    yv_d = 1'b1;
                end
                if (accept) begin
                    if (req_oor) begin
                        err_d = 1'b1;
                    end else if (sel_req != cur_sel) begin
                        if (BLANK == 0) begin
                            cur_d = sel_req;
                            y_d   = req_data;
                            yv_d  = 1'b1;
                        end else begin
                            state_d = ST_BLANK;
                            cnt_d   = CW'(1);
                            tgt_d   = sel_req;
                            y_d     = '0;
                            yv_d    = 1'b0;
                            busy_d  = 1'b1;
                            rdy_d   = 1'b0;
                        end
                    end
                end
            end
            ST_BLANK: begin
                // Exit edge loads the new channel regardless of hold.
                if (cnt_q >= BLANK_L) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    cur_d   = tgt_q;
                    y_d     = tgt_data;
                    yv_d    = 1'b1;
                    busy_d  = 1'b0;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            tgt_q     <= '0;
            cur_sel   <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            sel_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            cur_sel   <= cur_d;
            y         <= y_d;
            y_valid   <= yv_d;
            busy      <= busy_d;
            err       <= err_d;
            sel_ready <= rdy_d;
        end
    end

endmodule
